// File: rtl/seg7_onehot_decoder.sv
// Qualifies an active-low 7-segment digit over several samples and decodes
// it to a committed index, a one-hot LED vector, an update pulse and an error flag.
module seg7_onehot_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       valid_in,
    input  logic       err_clr,
    output logic [2:0] out_idx,
    output logic [7:0] out_onehot,
    output logic       out_valid,
    output logic       upd,
    output logic       err
);

    typedef enum logic {
        SETTLE,
        STABLE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    state_t           state;
    logic [7:0]       s_q;
    logic [CNT_W-1:0] cnt;

    logic       match;
    logic       dig_ok;
    logic [2:0] dig_idx;
    logic       blank;
    logic       legal;
    logic       commit;
    logic       new_valid;
    logic [2:0] new_idx;

    assign match = ({valid_in, seg_in} == s_q);

    always_comb begin
        dig_ok  = 1'b1;
        dig_idx = 3'd0;
        case (s_q[6:0])
            7'd64:   dig_idx = 3'd0;
            7'd121:  dig_idx = 3'd1;
            7'd36:   dig_idx = 3'd2;
            7'd48:   dig_idx = 3'd3;
            7'd25:   dig_idx = 3'd4;
            7'd18:   dig_idx = 3'd5;
            7'd2:    dig_idx = 3'd6;
            7'd120:  dig_idx = 3'd7;
            default: dig_ok  = 1'b0;
        endcase
    end

    assign blank     = (s_q[6:0] == 7'h7F);
    assign legal     = dig_ok | blank;
    assign commit    = match && (state == SETTLE) && (cnt == CNT_LAST);
    // A digit without valid_in is treated exactly like a blank.
    assign new_valid = dig_ok & s_q[7];
    assign new_idx   = new_valid ? dig_idx : 3'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q        <= {1'b0, 7'h7F};
            cnt        <= '0;
            state      <= SETTLE;
            out_idx    <= 3'd0;
            out_onehot <= 8'h00;
            out_valid  <= 1'b0;
            upd        <= 1'b0;
            err        <= 1'b0;
        end else begin
            s_q <= {valid_in, seg_in};
            upd <= 1'b0;

            case (state)
                SETTLE: begin
                    if (!match) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= STABLE;
                        if (legal) begin
                            out_valid  <= new_valid;
                            out_idx    <= new_idx;
                            out_onehot <= new_valid ? (8'h01 << new_idx) : 8'h00;
                            upd        <= ({new_valid, new_idx} != {out_valid, out_idx});
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!match) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= SETTLE;
                    cnt   <= '0;
                end
            endcase

            // Setting on an illegal commit beats a simultaneous clear.
            if (commit && !legal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_onehot_decoder.sv
// Bench for seg7_onehot_decoder: directed scenarios plus random held patterns,
// all compared against a run-length reference model.
module tb_seg7_onehot_decoder;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       valid_in;
    logic       err_clr;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       upd;
    logic       err;

    int tests = 0;
    int fails = 0;

    seg7_onehot_decoder #(.STABLE_CYCLES(SC), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .valid_in  (valid_in),
        .err_clr   (err_clr),
        .out_idx   (out_idx),
        .out_onehot(out_onehot),
        .out_valid (out_valid),
        .upd       (upd),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [6:0] codes [8] = '{7'd64, 7'd121, 7'd36, 7'd48,
                              7'd25, 7'd18, 7'd2, 7'd120};

    // reference model state
    logic [7:0] m_last;
    int         m_run;
    logic       m_valid;
    int         m_idx;
    logic       m_upd;
    logic       m_err;
    int         upd_seen;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 8; i++)
            if (codes[i] == s) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic v,
                              input logic [6:0] s, input logic c);
        int k;
        logic nv;
        int ni;
        if (!r) begin
            m_last  = {1'b0, 7'h7F};
            m_run   = 1;
            m_valid = 1'b0;
            m_idx   = 0;
            m_upd   = 1'b0;
            m_err   = 1'b0;
            return;
        end
        if ({v, s} == m_last) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_last = {v, s};
            m_run  = 1;
        end
        m_upd = 1'b0;
        if (m_run == SC) begin
            k = lookup(m_last[6:0]);
            if (k >= 0 || m_last[6:0] == 7'h7F) begin
                nv = (k >= 0) && m_last[7];
                ni = nv ? k : 0;
                m_upd   = (nv != m_valid) || (ni != m_idx);
                m_valid = nv;
                m_idx   = ni;
            end else begin
                m_err = 1'b1;
                return;
            end
        end
        if (c) m_err = 1'b0;
    endtask

    task automatic cyc(input logic r, input logic v,
                       input logic [6:0] s, input logic c);
        logic [7:0] oh;
        rst_n    = r;
        valid_in = v;
        seg_in   = s;
        err_clr  = c;
        @(posedge clk);
        model_edge(r, v, s, c);
        #1;
        oh = m_valid ? 8'(1 << m_idx) : 8'h00;
        check("out_idx", 32'(out_idx), 32'(m_idx));
        check("out_onehot", 32'(out_onehot), 32'(oh));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("upd", 32'(upd), 32'(m_upd));
        check("err", 32'(err), 32'(m_err));
        if (upd) upd_seen++;
    endtask

    task automatic hold(input logic v, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, v, s, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [6:0] s;
        logic v;
        rst_n = 1'b0; valid_in = 1'b0; seg_in = 7'h7F; err_clr = 1'b0;
        upd_seen = 0;

        cyc(1'b0, 1'b0, 7'h7F, 1'b0);
        cyc(1'b0, 1'b0, 7'h7F, 1'b0);
        check("rst_onehot", 32'(out_onehot), 32'h0);

        upd_seen = 0;
        hold(1'b0, 7'h7F, 10);
        check("blank_no_upd", 32'(upd_seen), 0);

        hold(1'b1, 7'd25, 3);
        check("idx4_not_yet", 32'(out_valid), 0);
        hold(1'b1, 7'd25, 1);
        check("idx4_onehot", 32'(out_onehot), 32'h10);
        check("idx4_upd", 32'(upd), 1);
        hold(1'b1, 7'd25, 1);
        check("idx4_upd_once", 32'(upd), 0);

        upd_seen = 0;
        hold(1'b1, 7'd2, 2);
        hold(1'b1, 7'd25, 6);
        check("glitch_idx", 32'(out_idx), 4);
        check("glitch_no_upd", 32'(upd_seen), 0);

        upd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            hold(1'b1, codes[i], 6);
            check("walk_onehot", 32'(out_onehot), 32'(1 << i));
        end
        check("walk_upd_count", 32'(upd_seen), 8);
        hold(1'b0, 7'd64, 6);
        check("novalid_valid", 32'(out_valid), 0);
        check("novalid_onehot", 32'(out_onehot), 0);

        hold(1'b1, 7'd18, 6);
        hold(1'b1, 7'h55, 4);
        check("illegal_err", 32'(err), 1);
        check("illegal_keep_idx", 32'(out_idx), 5);
        hold(1'b1, 7'h2A, 3);
        cyc(1'b1, 1'b1, 7'h2A, 1'b1);
        check("err_set_wins", 32'(err), 1);
        hold(1'b1, 7'd18, 5);
        cyc(1'b1, 1'b1, 7'd18, 1'b1);
        check("err_cleared", 32'(err), 0);

        hold(1'b1, 7'd120, 2);
        cyc(1'b0, 1'b1, 7'd120, 1'b0);
        check("mid_rst_valid", 32'(out_valid), 0);
        hold(1'b1, 7'd120, 3);
        check("post_rst_wait", 32'(out_valid), 0);
        hold(1'b1, 7'd120, 1);
        check("post_rst_idx7", 32'(out_idx), 7);
        check("post_rst_onehot", 32'(out_onehot), 32'h80);

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: s = 7'h7F;
                1: s = 7'($urandom);
                default: s = codes[$urandom_range(0, 7)];
            endcase
            v = ($urandom_range(0, 4) != 0);
            n = $urandom_range(1, 7);
            for (int j = 0; j < n; j++)
                cyc(($urandom_range(0, 199) != 0), v, s,
                    ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
